div_iter: RTL and testbench



---
 rtl/div_iter_pkg.sv | 18 +
 rtl/div_step.sv | 21 ++
 rtl/div_iter.sv | 116 +++++++++++
 tb/tb_div_iter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared encodings and constants for the iterative divider.
package div_iter_pkg;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } div_state_e;

   localparam int         DIV_STEPS     = 32;
   localparam logic [4:0] DIV_LAST_STEP = 5'(DIV_STEPS - 1);

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift left, trial-subtract the divisor from the upper half.
// Purely combinational, zero latency, no flow control.
module div_step (
   input  logic [64:0] work_i,
   input  logic [31:0] divisor_i,
   output logic [64:0] work_o
);

   logic [33:0] diff;

   // work_i[64:31] is the upper 34 bits of the shifted register, so no bit is lost.
   assign diff = work_i[64:31] - {2'b00, divisor_i};

   always_comb begin
      work_o = {work_i[63:0], 1'b0};
      if (!diff[33]) begin
         work_o = {diff[32:0], work_i[30:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_iter.sv
// 32-bit signed/unsigned iterative divider: 33 edges per divide (1 with a zero divisor, or with
// DIV_EARLY_OUT_EN when |dividend| < |divisor|); result held with ready until start_i drops.
module div_iter
   import div_iter_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_e  state_q;
   logic [4:0]  cnt_q;
   logic [64:0] work_q;
   logic [64:0] work_d;
   logic [31:0] dvsr_q;
   logic        quot_neg_q;
   logic        rem_neg_q;
   logic [63:0] result_q;
   logic        ready_q;

   logic        a_neg;
   logic        b_neg;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] quot_fin;
   logic [31:0] rem_fin;

   assign a_neg = signed_div_i & opdata1_i[31];
   assign b_neg = signed_div_i & opdata2_i[31];
   assign mag_a = a_neg ? -opdata1_i : opdata1_i;
   assign mag_b = b_neg ? -opdata2_i : opdata2_i;

   div_step u_step (
      .work_i    (work_q),
      .divisor_i (dvsr_q),
      .work_o    (work_d)
   );

   // Final sign correction is taken from the last step's output so DONE needs no extra cycle.
   assign quot_fin = quot_neg_q ? -work_d[31:0]  : work_d[31:0];
   assign rem_fin  = rem_neg_q  ? -work_d[63:32] : work_d[63:32];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 5'd0;
         work_q     <= 65'd0;
         dvsr_q     <= 32'd0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         result_q   <= 64'd0;
         ready_q    <= DivResultNotReady;
      end else if (annul_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         result_q <= 64'd0;
         ready_q  <= DivResultNotReady;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i == DivStart) begin
                  dvsr_q     <= mag_b;
                  quot_neg_q <= a_neg ^ b_neg;
                  rem_neg_q  <= a_neg;
                  cnt_q      <= 5'd0;
                  work_q     <= {33'd0, mag_a};
                  if (opdata2_i == 32'd0) begin
                     state_q  <= ST_DONE;
                     result_q <= 64'd0;
                     ready_q  <= DivResultReady;
                  end
`ifdef DIV_EARLY_OUT_EN
                  else if (mag_a < mag_b) begin
                     state_q  <= ST_DONE;
                     result_q <= {opdata1_i, 32'd0};
                     ready_q  <= DivResultReady;
                  end
`endif
                  else begin
                     state_q <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               work_q <= work_d;
               cnt_q  <= cnt_q + 5'd1;
               if (cnt_q == DIV_LAST_STEP) begin
                  state_q  <= ST_DONE;
                  result_q <= {rem_fin, quot_fin};
                  ready_q  <= DivResultReady;
               end
            end
            ST_DONE: begin
               if (start_i == DivStop) begin
                  state_q <= ST_IDLE;
                  ready_q <= DivResultNotReady;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= DivResultNotReady;
            end
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed table-driven bench for div_iter plus annul and reset sequences.
module tb_div_iter;

   logic        clk;
   logic        resetn;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
      int          lat_early;
   } vec_t;

   vec_t vecs[12];

   div_iter dut (
      .clk          (clk),
      .resetn       (resetn),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a divide, counts edges to ready, checks hold and release of ready.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
      int n;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      n = 0;
      while (n < 40 && ready_o !== 1'b1) begin
         tick();
         n++;
         if (n == 1) begin
            opdata1_i    = 32'hDEAD_BEEF;
            opdata2_i    = 32'h0000_0003;
            signed_div_i = ~sgn;
         end
      end
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " result"}, result_o, exp);
      tick();
      check({tag, " ready held"}, 64'(ready_o), 64'd1);
      check({tag, " result held"}, result_o, exp);
      start_i = 1'b0;
      tick();
      check({tag, " ready fall"}, 64'(ready_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}, 33, 33};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33};
      vecs[2]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 33};
      vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, 33};
      vecs[4]  = '{1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0, 1, 1};
      vecs[5]  = '{1'b1, 32'h8000_0000, 32'h0000_0000, 64'h0, 1, 1};
      vecs[6]  = '{1'b0, 32'h0000_0003, 32'h0000_0009, {32'h0000_0003, 32'h0000_0000}, 33, 1};
      vecs[7]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0009, {32'hFFFF_FFFD, 32'h0000_0000}, 33, 1};
      vecs[8]  = '{1'b0, 32'h0000_0064, 32'h0000_0007, {32'h0000_0002, 32'h0000_000E}, 33, 33};
      vecs[9]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 33, 1};
      vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF}, 33, 33};
      vecs[11] = '{1'b1, 32'h0000_0064, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 33, 33};

      resetn       = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      tick();
      tick();
      check("reset ready", 64'(ready_o), 64'd0);
      check("reset result", result_o, 64'd0);
      resetn = 1'b1;
      tick();
      check("idle ready", 64'(ready_o), 64'd0);

      for (int i = 0; i < 12; i++) begin
`ifdef DIV_EARLY_OUT_EN
         run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat_early);
`else
         run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
`endif
      end

      // Annul at step 10 of BUSY: no result, then a fresh 100/7.
      signed_div_i = 1'b0;
      opdata1_i    = 32'h0001_0000;
      opdata2_i    = 32'h0000_0003;
      start_i      = 1'b1;
      repeat (11) tick();
      check("annul pre ready", 64'(ready_o), 64'd0);
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      check("annul ready", 64'(ready_o), 64'd0);
      check("annul result", result_o, 64'd0);
      annul_i = 1'b0;
      repeat (25) begin
         tick();
         check("annul no late ready", 64'(ready_o), 64'd0);
      end
      run_div("post annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

      // Annul beats completion: annul on the last step.
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      start_i   = 1'b1;
      repeat (32) tick();
      annul_i = 1'b1;
      tick();
      check("annul at completion", 64'(ready_o), 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      tick();

      // A completed result then reset mid-BUSY.
      run_div("pre reset", 1'b0, 32'd45, 32'd6, {32'd3, 32'd7}, 33);
      opdata1_i = 32'h0000_FFFF;
      opdata2_i = 32'h0000_0005;
      start_i   = 1'b1;
      repeat (5) tick();
      resetn = 1'b0;
      #1;
      check("mid reset ready", 64'(ready_o), 64'd0);
      check("mid reset result", result_o, 64'd0);
      start_i = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      check("post reset idle", 64'(ready_o), 64'd0);
      run_div("post reset", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
